// File: rtl/ar_src_arbiter.sv
// rtl/ar_src_arbiter.sv - round-robin AR arbiter with per-source credit limit and registered output stage
//
// Purpose:
//   Shares one AR request path among NUM_SRC masters. Picks a winner round-robin
//   from rr_ptr among sources that are valid and still have outstanding credit.
//   The winner is loaded into a single registered output entry. Completions
//   (done_valid/done_src) return credits. m_tagid carries the winning source index
//   so the read path can route R bursts back to their source.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   per-source AR handshake (s_ready is one-hot or zero)
//   s_id..s_qos       packed per-source AR fields, source i in slice i
//   m_valid/m_ready   registered AR handshake toward the request buffer
//   m_id..m_qos       registered AR fields of the held entry
//   m_tagid           source index of the held entry, zero-extended
//   done_valid/src    credit return for one completed request of done_src
//   err_underflow     sticky: credit returned with no outstanding request, or bad index
//
// Configuration:
//   AR_ARB_QOS_EN     when defined, only eligible sources at the highest eligible
//                     s_qos take part in the round-robin; otherwise s_qos is only
//                     passed through to m_qos.

module ar_src_arbiter #(
  parameter  int NUM_SRC         = 4,
  parameter  int ID_WIDTH        = 4,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int LEN_WIDTH       = 8,
  parameter  int TAG_WIDTH       = 4,
  parameter  int MAX_OUTSTANDING = 8,
  localparam int SRC_W           = $clog2(NUM_SRC),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0]               s_valid,
  output logic [NUM_SRC-1:0]               s_ready,
  input  logic [NUM_SRC*ID_WIDTH-1:0]      s_id,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]    s_addr,
  input  logic [NUM_SRC*LEN_WIDTH-1:0]     s_len,
  input  logic [NUM_SRC*3-1:0]             s_size,
  input  logic [NUM_SRC*2-1:0]             s_burst,
  input  logic [NUM_SRC*4-1:0]             s_qos,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [LEN_WIDTH-1:0]             m_len,
  output logic [2:0]                       m_size,
  output logic [1:0]                       m_burst,
  output logic [3:0]                       m_qos,
  output logic [TAG_WIDTH-1:0]             m_tagid,
  input  logic                             done_valid,
  input  logic [SRC_W-1:0]                 done_src,
  output logic                             err_underflow
);

  localparam int                 SRC_W1    = SRC_W + 1;
  localparam logic [SRC_W:0]     NUM_SRC_X = SRC_W1'(NUM_SRC);
  localparam logic [SRC_W-1:0]   LAST_SRC  = SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q [NUM_SRC];
  logic [CNT_W-1:0]        cnt_d [NUM_SRC];
  logic                    err_q, err_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [3:0]              qos_q, qos_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;

  logic [ID_WIDTH-1:0]     src_id    [NUM_SRC];
  logic [ADDR_WIDTH-1:0]   src_addr  [NUM_SRC];
  logic [LEN_WIDTH-1:0]    src_len   [NUM_SRC];
  logic [2:0]              src_size  [NUM_SRC];
  logic [1:0]              src_burst [NUM_SRC];
  logic [3:0]              src_qos   [NUM_SRC];

  logic [NUM_SRC-1:0]      eligible;
  logic [NUM_SRC-1:0]      candidate;
  logic [NUM_SRC-1:0]      dec_vec;
  logic [SRC_W:0]          scan;
  logic [SRC_W-1:0]        grant_idx;
  logic                    grant_found;
  logic                    can_load;
  logic                    grant;
  logic                    done_in_range;
  logic                    done_cnt_zero;

  // Unpack the flat per-source buses into arrays indexed by source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_id[i]    = s_id[i*ID_WIDTH +: ID_WIDTH];
      src_addr[i]  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      src_len[i]   = s_len[i*LEN_WIDTH +: LEN_WIDTH];
      src_size[i]  = s_size[i*3 +: 3];
      src_burst[i] = s_burst[i*2 +: 2];
      src_qos[i]   = s_qos[i*4 +: 4];
      eligible[i]  = s_valid[i] & (cnt_q[i] < MAX_CNT);
    end
  end

`ifdef AR_ARB_QOS_EN
  logic [3:0] max_qos;

  always_comb begin
    max_qos = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (src_qos[i] > max_qos)) max_qos = src_qos[i];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      candidate[i] = eligible[i] & (src_qos[i] == max_qos);
    end
  end
`else
  assign candidate = eligible;
`endif

  // First candidate at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = {1'b0, rr_ptr_q} + SRC_W1'(k);
      if (scan >= NUM_SRC_X) scan = scan - NUM_SRC_X;
      if (!grant_found && candidate[scan[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[SRC_W-1:0];
      end
    end
  end

  assign can_load = (state_q == S_EMPTY) | m_ready;
  // Reset masks grants so no source sees a handshake that the state would drop.
  assign grant    = grant_found & can_load & ~rst;
  assign s_ready  = grant ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << grant_idx) : '0;

  assign done_in_range = ({1'b0, done_src} < NUM_SRC_X);
  assign done_cnt_zero = done_in_range ? (cnt_q[done_src] == '0) : 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      dec_vec[i] = done_valid & done_in_range & (done_src == SRC_W'(i)) & (cnt_q[i] != '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    qos_d    = qos_q;
    tag_d    = tag_q;

    // A simultaneous grant and credit return on one source cancel out.
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({s_ready[i], dec_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    if (done_valid && done_cnt_zero) err_d = 1'b1;

    if (grant) begin
      state_d  = S_FULL;
      id_d     = src_id[grant_idx];
      addr_d   = src_addr[grant_idx];
      len_d    = src_len[grant_idx];
      size_d   = src_size[grant_idx];
      burst_d  = src_burst[grant_idx];
      qos_d    = src_qos[grant_idx];
      tag_d    = TAG_WIDTH'(grant_idx);
      rr_ptr_d = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == S_FULL) && m_ready) begin
      // Entry drained; payload registers keep their last value.
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      qos_q    <= '0;
      tag_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      qos_q    <= qos_d;
      tag_q    <= tag_d;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign m_valid       = (state_q == S_FULL);
  assign m_id          = id_q;
  assign m_addr        = addr_q;
  assign m_len         = len_q;
  assign m_size        = size_q;
  assign m_burst       = burst_q;
  assign m_qos         = qos_q;
  assign m_tagid       = tag_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ar_src_arbiter.sv
// tb/tb_ar_src_arbiter.sv - self-checking bench for ar_src_arbiter
module tb_ar_src_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 4;
  localparam int AW   = 32;
  localparam int LW   = 8;
  localparam int TW   = 4;
  localparam int MAXO = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*IDW-1:0] s_id;
  logic [N*AW-1:0] s_addr;
  logic [N*LW-1:0] s_len;
  logic [N*3-1:0]  s_size;
  logic [N*2-1:0]  s_burst;
  logic [N*4-1:0]  s_qos;
  logic            m_valid;
  logic            m_ready;
  logic [IDW-1:0]  m_id;
  logic [AW-1:0]   m_addr;
  logic [LW-1:0]   m_len;
  logic [2:0]      m_size;
  logic [1:0]      m_burst;
  logic [3:0]      m_qos;
  logic [TW-1:0]   m_tagid;
  logic            done_valid;
  logic [1:0]      done_src;
  logic            err_underflow;

  logic [IDW-1:0]  a_id    [N];
  logic [AW-1:0]   a_addr  [N];
  logic [LW-1:0]   a_len   [N];
  logic [2:0]      a_size  [N];
  logic [1:0]      a_burst [N];
  logic [3:0]      a_qos   [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_id[i*IDW +: IDW] = a_id[i];
      s_addr[i*AW +: AW] = a_addr[i];
      s_len[i*LW +: LW]  = a_len[i];
      s_size[i*3 +: 3]   = a_size[i];
      s_burst[i*2 +: 2]  = a_burst[i];
      s_qos[i*4 +: 4]    = a_qos[i];
    end
  end

  ar_src_arbiter #(
    .NUM_SRC(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_id(s_id), .s_addr(s_addr), .s_len(s_len), .s_size(s_size),
    .s_burst(s_burst), .s_qos(s_qos),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_id(m_id), .m_addr(m_addr), .m_len(m_len), .m_size(m_size),
    .m_burst(m_burst), .m_qos(m_qos), .m_tagid(m_tagid),
    .done_valid(done_valid), .done_src(done_src),
    .err_underflow(err_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: integer pointer, per-source credit counts, one held entry.
  int             mp = 0;
  int             mcnt [N] = '{0, 0, 0, 0};
  bit             merr = 1'b0;
  bit             mv   = 1'b0;
  logic [IDW-1:0] mid  = '0;
  logic [AW-1:0]  maddr = '0;
  logic [LW-1:0]  mlen = '0;
  logic [2:0]     msize = '0;
  logic [1:0]     mburst = '0;
  logic [3:0]     mqos = '0;
  logic [TW-1:0]  mtag = '0;

  int             w;
  logic [N-1:0]   exp_ready;
  int             t1_tags [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    int maxq = -1;
    int i;
    if (rst) return -1;
    if (mv && !m_ready) return -1;
    for (int k = 0; k < N; k++)
      if (s_valid[k] && mcnt[k] < MAXO && int'(a_qos[k]) > maxq) maxq = int'(a_qos[k]);
    for (int k = 0; k < N; k++) begin
      i = (mp + k) % N;
      if (s_valid[i] && mcnt[i] < MAXO) begin
`ifdef AR_ARB_QOS_EN
        if (int'(a_qos[i]) == maxq) return i;
`else
        return i;
`endif
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int win);
    if (rst) begin
      mp = 0; merr = 1'b0; mv = 1'b0;
      for (int k = 0; k < N; k++) mcnt[k] = 0;
      mid = '0; maddr = '0; mlen = '0; msize = '0; mburst = '0; mqos = '0; mtag = '0;
      return;
    end
    if (done_valid) begin
      if (int'(done_src) >= N || mcnt[done_src] == 0) merr = 1'b1;
      else mcnt[done_src]--;
    end
    if (win >= 0) begin
      mcnt[win]++;
      mv = 1'b1;
      mid = a_id[win]; maddr = a_addr[win]; mlen = a_len[win];
      msize = a_size[win]; mburst = a_burst[win]; mqos = a_qos[win];
      mtag = win[TW-1:0];
      mp = (win + 1) % N;
    end else if (mv && m_ready) begin
      mv = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      w = model_winner();
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("s_ready", 64'(s_ready), 64'(exp_ready));
      chk("m_valid", 64'(m_valid), 64'(mv));
      chk("m_tagid", 64'(m_tagid), 64'(mtag));
      chk("m_payload", 64'({m_id, m_addr, m_len, m_size, m_burst, m_qos}),
          64'({mid, maddr, mlen, msize, mburst, mqos}));
      chk("err_underflow", 64'(err_underflow), 64'(merr));
      model_step(w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input int src);
    done_valid = 1'b1;
    done_src   = src[1:0];
    tick();
    done_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 4'b1111; m_ready = 1'b0; done_valid = 1'b0; done_src = 2'd0;
    for (int k = 0; k < N; k++) begin
      a_id[k]    = 4'(k + 1);
      a_addr[k]  = 32'h1000_0000 * (k + 1);
      a_len[k]   = 8'(k * 3);
      a_size[k]  = 3'(k);
      a_burst[k] = 2'b01;
      a_qos[k]   = 4'd0;
    end
    tick();
    chk("rst_s_ready_masked", 64'(s_ready), 64'd0);
    s_valid = 4'b0000;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_tagid", 64'(m_tagid), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);

    // 1: all sources valid, output always drained -> 0,1,2,3,0
    s_valid = 4'b1111; m_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t1_s_ready", 64'(s_ready), 64'(4'b0001 << t1_tags[k]));
      tick();
      chk("t1_tagid", 64'(m_tagid), 64'(t1_tags[k]));
      chk("t1_m_valid", 64'(m_valid), 64'd1);
    end
    s_valid = 4'b0000;
    tick();
    chk("t1_drain", 64'(m_valid), 64'd0);
    ret(0); ret(0); ret(1); ret(2); ret(3);
    chk("t1_model_cnt0", 64'(mcnt[0]), 64'd0);
    chk("t1_err", 64'(err_underflow), 64'd0);

    // 2: backpressure holds the entry stable
    m_ready = 1'b0; s_valid = 4'b0100; a_addr[2] = 32'hA2A2_0000; #1;
    chk("t2_s_ready_load", 64'(s_ready), 64'b0100);
    tick();
    chk("t2_tagid", 64'(m_tagid), 64'd2);
    s_valid = 4'b1111; a_addr[2] = 32'hDEAD_0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_hold_valid", 64'(m_valid), 64'd1);
      chk("t2_hold_tag", 64'(m_tagid), 64'd2);
      chk("t2_hold_addr", 64'(m_addr), 64'hA2A2_0000);
      chk("t2_hold_s_ready", 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1; #1;
    chk("t2_s_ready_release", 64'(s_ready), 64'b1000);
    tick();
    chk("t2_next_tag", 64'(m_tagid), 64'd3);
    chk("t2_next_valid", 64'(m_valid), 64'd1);
    s_valid = 4'b0000;
    tick();
    ret(2); ret(3);

    // 3: credit limit on src1 and release by completion
    s_valid = 4'b0010; #1;
    chk("t3_s_ready_a", 64'(s_ready), 64'b0010);
    tick();
    chk("t3_tag_a", 64'(m_tagid), 64'd1);
    chk("t3_s_ready_b", 64'(s_ready), 64'b0010);
    tick();
    chk("t3_tag_b", 64'(m_tagid), 64'd1);
    chk("t3_blocked", 64'(s_ready), 64'd0);
    tick();
    chk("t3_drained", 64'(m_valid), 64'd0);
    done_valid = 1'b1; done_src = 2'd1; #1;
    chk("t3_blocked_same_cycle", 64'(s_ready), 64'd0);
    tick();
    done_valid = 1'b0; #1;
    chk("t3_unblocked", 64'(s_ready), 64'b0010);
    tick();
    chk("t3_tag_c", 64'(m_tagid), 64'd1);
    chk("t3_valid_c", 64'(m_valid), 64'd1);
    s_valid = 4'b0000;
    tick();
    ret(1); ret(1);

    // 4: grant and completion on the same source cancel; underflow is sticky
    chk("t4_err_before", 64'(err_underflow), 64'd0);
    s_valid = 4'b0100; #1;
    tick();
    chk("t4_tag_a", 64'(m_tagid), 64'd2);
    done_valid = 1'b1; done_src = 2'd2; #1;
    chk("t4_s_ready_b", 64'(s_ready), 64'b0100);
    tick();
    done_valid = 1'b0; #1;
    chk("t4_model_cnt2", 64'(mcnt[2]), 64'd1);
    chk("t4_s_ready_c", 64'(s_ready), 64'b0100);
    tick();
    chk("t4_tag_c", 64'(m_tagid), 64'd2);
    chk("t4_full_credit", 64'(s_ready), 64'd0);
    s_valid = 4'b0000; done_valid = 1'b1; done_src = 2'd3;
    tick();
    done_valid = 1'b0;
    chk("t4_err_set", 64'(err_underflow), 64'd1);
    ret(2); ret(2);
    chk("t4_err_sticky", 64'(err_underflow), 64'd1);

    // 5: QoS: rr_ptr=0, src0 qos=1, src2 qos=7
    s_valid = 4'b1000;
    tick();
    s_valid = 4'b0000;
    tick();
    ret(3);
    a_qos[0] = 4'd1; a_qos[2] = 4'd7; s_valid = 4'b0101; #1;
`ifdef AR_ARB_QOS_EN
    chk("t5_s_ready_qos", 64'(s_ready), 64'b0100);
    tick();
    chk("t5_tag_qos", 64'(m_tagid), 64'd2);
`else
    chk("t5_s_ready_rr", 64'(s_ready), 64'b0001);
    tick();
    chk("t5_tag_rr", 64'(m_tagid), 64'd0);
`endif
    tick();
    tick();

    // 6: reset mid-operation with a held entry and src0 at full credit
    s_valid = 4'b0001;
    for (int k = 0; k < 4 && mcnt[0] < MAXO; k++) tick();
    chk("t6_model_cnt0_full", 64'(mcnt[0]), 64'(MAXO));
    s_valid = 4'b0000; m_ready = 1'b0;
    tick();
    chk("t6_held", 64'(m_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_m_valid", 64'(m_valid), 64'd0);
    chk("t6_err", 64'(err_underflow), 64'd0);
    chk("t6_tagid", 64'(m_tagid), 64'd0);
    chk("t6_addr", 64'(m_addr), 64'd0);
    a_qos[0] = 4'd0; a_qos[2] = 4'd0;
    s_valid = 4'b1111; m_ready = 1'b1; #1;
    chk("t6_ptr_zero", 64'(s_ready), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_tagid_seq", 64'(m_tagid), 64'(t1_tags[k]));
    end
    s_valid = 4'b0000;
    tick();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
